// File: rtl/arb_l0_multi_if.sv
// MemSplit32 request/ack + resp/rdata channel bundle; N lanes packed side by side
// (lane k uses bit k, or slice [k*32 +: 32] / [k*4 +: 4]).
interface arb_l0_multi_if #(
  parameter int N = 1
) ();
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*32-1:0] addr;
  logic [N*4-1:0]  be;
  logic [N*32-1:0] wdata;
  logic [N-1:0]    ack;
  logic [N-1:0]    resp;
  logic [N*32-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );
endinterface

// File: rtl/arb_l0_multi.sv
// Single-master to N-slave address-decoded router with in-order outstanding reads
// and an internal error slave for unmapped addresses.
module arb_l0_multi #(
  parameter int          NUM_SLAVES      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hDEADBEEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  arb_l0_multi_if.slave  m,
  arb_l0_multi_if.master s
);

  localparam int SEL_W  = $clog2(NUM_SLAVES);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int RSEL_W = $clog2(NUM_SLAVES + 1);
  localparam logic [RSEL_W-1:0] ERR_SEL = RSEL_W'(NUM_SLAVES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]  rd_cnt;
  logic [RSEL_W-1:0] rd_sel;
  logic              err_resp_q;

  logic [SEL_W-1:0]  idx;
  logic [RSEL_W-1:0] tgt;
  logic              tgt_err;
  logic              lim_block;
  logic              fwd;
  logic              accept;

  logic                     ack_d;
  logic                     resp_d;
  logic [31:0]              rdata_d;
  logic [NUM_SLAVES-1:0]    s_req_d;
  logic [NUM_SLAVES-1:0]    s_we_d;
  logic [NUM_SLAVES*32-1:0] s_addr_d;
  logic [NUM_SLAVES*4-1:0]  s_be_d;
  logic [NUM_SLAVES*32-1:0] s_wdata_d;

  assign idx     = m.addr[31 -: SEL_W];
  assign tgt_err = (RSEL_W'(idx) >= ERR_SEL);
  assign tgt     = tgt_err ? ERR_SEL : RSEL_W'(idx);

  always_comb begin
    resp_d  = 1'b0;
    rdata_d = '0;
    if (rd_cnt != '0) begin
      if (rd_sel == ERR_SEL) begin
        resp_d  = err_resp_q;
        rdata_d = ERR_RDATA;
      end else begin
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
          if (rd_sel == RSEL_W'(k)) begin
            resp_d  = s.resp[k];
            rdata_d = s.rdata[k*32 +: 32];
          end
        end
      end
    end
  end

  // A read at the limit may proceed in the cycle a response retires one,
  // so a full pipe keeps rd_cnt at MAX instead of bubbling through MAX-1.
  assign lim_block = !m.we[0] && (rd_cnt == CNT_MAX) && !resp_d;
  assign fwd       = m.req[0] && ((rd_cnt == '0) || (tgt == rd_sel)) && !lim_block;

  always_comb begin
    ack_d     = 1'b0;
    s_req_d   = '0;
    s_we_d    = '0;
    s_addr_d  = '0;
    s_be_d    = '0;
    s_wdata_d = '0;
    if (fwd && tgt_err) begin
      ack_d = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (fwd && !tgt_err && (tgt == RSEL_W'(k))) begin
        s_req_d[k]            = 1'b1;
        s_we_d[k]             = m.we[0];
        s_addr_d[k*32 +: 32]  = m.addr;
        s_be_d[k*4 +: 4]      = m.be;
        s_wdata_d[k*32 +: 32] = m.wdata;
        ack_d                 = s.ack[k];
      end
    end
  end

  assign accept = m.req[0] && !m.we[0] && ack_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt     <= '0;
      rd_sel     <= '0;
      err_resp_q <= 1'b0;
    end else begin
      err_resp_q <= accept && tgt_err;
      if (accept) begin
        rd_sel <= tgt;
      end
      if (accept && !resp_d) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end else if (!accept && resp_d) begin
        rd_cnt <= rd_cnt - CNT_W'(1);
      end
    end
  end

  assign m.ack   = ack_d;
  assign m.resp  = resp_d;
  assign m.rdata = rdata_d;
  assign s.req   = s_req_d;
  assign s.we    = s_we_d;
  assign s.addr  = s_addr_d;
  assign s.be    = s_be_d;
  assign s.wdata = s_wdata_d;

endmodule

// File: tb/tb_arb_l0_multi.sv
// Directed bench for arb_l0_multi: a 4-slave and a 3-slave instance, read data
// checked by a queue-based monitor, request-path values checked inline.
module tb_arb_l0_multi;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  logic [31:0] q4[$];
  logic [31:0] q3[$];

  arb_l0_multi_if #(.N(1)) mi4 ();
  arb_l0_multi_if #(.N(4)) si4 ();
  arb_l0_multi_if #(.N(1)) mi3 ();
  arb_l0_multi_if #(.N(3)) si3 ();

  arb_l0_multi #(
    .NUM_SLAVES(4), .MAX_OUTSTANDING(2), .ERR_RDATA(32'hDEADBEEF)
  ) u4 (
    .clk_i(clk), .rst_i(rst_n), .m(mi4), .s(si4)
  );

  arb_l0_multi #(
    .NUM_SLAVES(3), .MAX_OUTSTANDING(2), .ERR_RDATA(32'hDEADBEEF)
  ) u3 (
    .clk_i(clk), .rst_i(rst_n), .m(mi3), .s(si3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mi4.resp[0] === 1'b1) begin
      if (q4.size() == 0) chk("u4 unexpected m_resp", 128'd1, 128'd0);
      else chk("u4 m_rdata", {96'd0, mi4.rdata}, {96'd0, q4.pop_front()});
    end
    if (mi3.resp[0] === 1'b1) begin
      if (q3.size() == 0) chk("u3 unexpected m_resp", 128'd1, 128'd0);
      else chk("u3 m_rdata", {96'd0, mi3.rdata}, {96'd0, q3.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mi4.req = '0; mi4.we = '0; mi4.addr = '0; mi4.be = '0; mi4.wdata = '0;
    si4.ack = '0; si4.resp = '0; si4.rdata = '0;
    mi3.req = '0; mi3.we = '0; mi3.addr = '0; mi3.be = '0; mi3.wdata = '0;
    si3.ack = '0; si3.resp = '0; si3.rdata = '0;
  endtask

  task automatic rd4(input logic [31:0] a, input logic [3:0] ack);
    mi4.req = 1'b1; mi4.we = 1'b0; mi4.addr = a; mi4.be = 4'hF; mi4.wdata = '0;
    si4.ack = ack;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
    #12;
    chk("rst m_ack",   {127'd0, mi4.ack},   128'd0);
    chk("rst m_resp",  {127'd0, mi4.resp},  128'd0);
    chk("rst m_rdata", {96'd0, mi4.rdata},  128'd0);
    chk("rst s_req",   {124'd0, si4.req},   128'd0);
    chk("rst s_bus",   {si4.addr, si4.wdata[31:0]}, 128'd0);
    chk("rst rd_cnt",  {126'd0, u4.rd_cnt}, 128'd0);
    chk("rst u3 out",  {126'd0, mi3.ack, mi3.resp}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // write to slave 1, then read from slave 3
    mi4.req = 1'b1; mi4.we = 1'b1; mi4.addr = 32'h4000_0010; mi4.be = 4'hF;
    mi4.wdata = 32'hA5A5_5A5A; si4.ack = 4'b0010;
    #2;
    chk("wr s_req",   {124'd0, si4.req}, {124'd0, 4'b0010});
    chk("wr s_we",    {124'd0, si4.we},  {124'd0, 4'b0010});
    chk("wr s_addr1", {96'd0, si4.addr[32 +: 32]}, {96'd0, 32'h4000_0010});
    chk("wr s_wdata1",{96'd0, si4.wdata[32 +: 32]}, {96'd0, 32'hA5A5_5A5A});
    chk("wr s_addr0", {96'd0, si4.addr[0 +: 32]}, 128'd0);
    chk("wr m_ack",   {127'd0, mi4.ack}, 128'd1);
    tick();
    rd4(32'hC000_0000, 4'b1000);
    #2;
    chk("rd3 s_req",  {124'd0, si4.req}, {124'd0, 4'b1000});
    chk("rd3 m_ack",  {127'd0, mi4.ack}, 128'd1);
    q4.push_back(32'h1234_5678);
    tick();
    idle();
    si4.resp = 4'b1000; si4.rdata[96 +: 32] = 32'h1234_5678;
    #2;
    chk("rd3 m_resp", {127'd0, mi4.resp}, 128'd1);
    tick();
    idle();
    #2;
    chk("rd3 rd_cnt end", {126'd0, u4.rd_cnt}, 128'd0);

    // outstanding limit on slave 0
    rd4(32'h0000_0000, 4'b0001);
    #2;
    chk("lim rd1 ack", {127'd0, mi4.ack}, 128'd1);
    q4.push_back(32'h1111_0001);
    tick();
    #2;
    chk("lim rd2 ack", {127'd0, mi4.ack}, 128'd1);
    q4.push_back(32'h1111_0002);
    tick();
    #2;
    chk("lim rd3 stall ack", {127'd0, mi4.ack}, 128'd0);
    chk("lim rd3 stall s_req", {124'd0, si4.req}, 128'd0);
    tick();
    si4.resp = 4'b0001; si4.rdata[0 +: 32] = 32'h1111_0001;
    #2;
    chk("lim rd3 ack on resp", {127'd0, mi4.ack}, 128'd1);
    q4.push_back(32'h1111_0003);
    tick();
    mi4.req = 1'b0; si4.ack = '0;
    si4.rdata[0 +: 32] = 32'h1111_0002;
    #2;
    chk("lim rd_cnt held", {126'd0, u4.rd_cnt}, 128'd2);
    tick();
    si4.rdata[0 +: 32] = 32'h1111_0003;
    tick();
    idle();
    #2;
    chk("lim rd_cnt end", {126'd0, u4.rd_cnt}, 128'd0);

    // retarget stall: slave 1 outstanding, then slave 2
    rd4(32'h4000_0000, 4'b0010);
    q4.push_back(32'hCAFE_0001);
    tick();
    rd4(32'h8000_0000, 4'b0100);
    si4.resp = 4'b0100; si4.rdata[64 +: 32] = 32'hBAD0_BAD0;
    #2;
    chk("rt stall ack", {127'd0, mi4.ack}, 128'd0);
    chk("rt stall s_req", {124'd0, si4.req}, 128'd0);
    chk("rt no passthru", {127'd0, mi4.resp}, 128'd0);
    tick();
    si4.resp = 4'b0010; si4.rdata[32 +: 32] = 32'hCAFE_0001;
    #2;
    chk("rt release cyc ack", {127'd0, mi4.ack}, 128'd0);
    chk("rt release cyc s_req", {124'd0, si4.req}, 128'd0);
    tick();
    si4.resp = '0;
    #2;
    chk("rt fwd ack", {127'd0, mi4.ack}, 128'd1);
    chk("rt fwd s_req", {124'd0, si4.req}, {124'd0, 4'b0100});
    q4.push_back(32'hCAFE_0002);
    tick();
    idle();
    si4.resp = 4'b0100; si4.rdata[64 +: 32] = 32'hCAFE_0002;
    tick();
    idle();

    // stray response while idle
    si4.resp = 4'b0100; si4.rdata[64 +: 32] = 32'h5555_AAAA;
    #2;
    chk("stray m_resp", {127'd0, mi4.resp}, 128'd0);
    tick();
    idle();
    #2;
    chk("stray rd_cnt", {126'd0, u4.rd_cnt}, 128'd0);

    // error slave on the 3-slave instance
    mi3.req = 1'b1; mi3.we = 1'b0; mi3.addr = 32'hC000_0004; mi3.be = 4'hF;
    si3.ack = 3'b111;
    #2;
    chk("err rd1 ack", {127'd0, mi3.ack}, 128'd1);
    chk("err rd1 s_req", {125'd0, si3.req}, 128'd0);
    q3.push_back(32'hDEAD_BEEF);
    tick();
    #2;
    chk("err rd2 ack", {127'd0, mi3.ack}, 128'd1);
    chk("err rd2 m_resp", {127'd0, mi3.resp}, 128'd1);
    q3.push_back(32'hDEAD_BEEF);
    tick();
    mi3.we = 1'b1; mi3.addr = 32'hC000_0000; mi3.wdata = 32'h0F0F_0F0F;
    #2;
    chk("err wr ack", {127'd0, mi3.ack}, 128'd1);
    chk("err wr s_req", {125'd0, si3.req}, 128'd0);
    chk("err wr s_we", {125'd0, si3.we}, 128'd0);
    tick();
    mi3.we = 1'b0; mi3.addr = 32'h8000_0008; si3.ack = 3'b100;
    #2;
    chk("u3 map s_req", {125'd0, si3.req}, {125'd0, 3'b100});
    chk("u3 map rd_cnt", {126'd0, u3.rd_cnt}, 128'd0);
    q3.push_back(32'h3333_0002);
    tick();
    idle();
    si3.resp = 3'b100; si3.rdata[64 +: 32] = 32'h3333_0002;
    tick();
    idle();
    #2;
    chk("u3 rd_cnt end", {126'd0, u3.rd_cnt}, 128'd0);

    // async reset with two reads outstanding
    rd4(32'h0000_0000, 4'b0001);
    tick();
    tick();
    idle();
    #2;
    chk("pre-rst rd_cnt", {126'd0, u4.rd_cnt}, 128'd2);
    si4.resp = 4'b0001; si4.rdata[0 +: 32] = 32'h0BAD_F00D;
    rst_n = 1'b0;
    #1;
    chk("async rst m_resp", {127'd0, mi4.resp}, 128'd0);
    chk("async rst rd_cnt", {126'd0, u4.rd_cnt}, 128'd0);
    tick();
    rst_n = 1'b1;
    rd4(32'h0000_0000, 4'b0001);
    #2;
    chk("post-rst ack", {127'd0, mi4.ack}, 128'd1);
    chk("post-rst late resp", {127'd0, mi4.resp}, 128'd0);
    q4.push_back(32'h6666_0006);
    tick();
    mi4.req = 1'b0; si4.ack = '0;
    si4.resp = 4'b0001; si4.rdata[0 +: 32] = 32'h6666_0006;
    tick();
    idle();
    tick();
    chk("post-rst rd_cnt", {126'd0, u4.rd_cnt}, 128'd0);

    chk("q4 drained", 128'(q4.size()), 128'd0);
    chk("q3 drained", 128'(q3.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
